if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Small instruction buffer between the fetch stage and the decode stage. Decode contains the immediate generator.
- Holds {pc, instruction} pairs pushed by fetch and presents the oldest entry to decode through a valid/ready handshake.
- Decouples instruction-memory/cache stalls from decode and discards wrong-path instructions on a branch flush.
- When empty, decode sees a canonical NOP, so the immediate generator and control decode get benign input.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- PTR_W, 1, log2(DEPTH); pointer width.
- NOP_INSTR, 32'h00000013, instruction driven on pop_instr_o when empty (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discard all entries (branch taken / mispredict).
- push_valid_i  in  1  fetch offers an entry this cycle.
- push_ready_o  out  1  queue can accept an entry; equals !full.
- push_pc_i  in  32  PC of the offered instruction.
- push_instr_i  in  32  offered instruction word.
- pop_valid_o  out  1  head entry valid; equals !empty.
- pop_ready_i  in  1  decode consumes the head this cycle.
- pop_pc_o  out  32  head PC; 0 when empty.
- pop_instr_o  out  32  head instruction; NOP_INSTR when empty.
- count_o  out  PTR_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (rst_i low, asynchronous):
  - Pointers and count go to 0; storage is not required to be cleared.
  - Outputs: push_ready_o=1, pop_valid_o=0, pop_pc_o=0, pop_instr_o=NOP_INSTR, count_o=0.
  - Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Storage and pointers:
  - Circular buffer with wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH) and a count register.
  - full = (count==DEPTH); empty = (count==0).
- Push fires when push_valid_i & push_ready_o at the clock edge. The entry is written at wr_ptr, then wr_ptr increments.
- Pop fires when pop_valid_o & pop_ready_i at the clock edge. rd_ptr then increments.
- Counting:
  - Both fire in the same cycle: count is unchanged and both pointers advance.
  - Only push fires: count+1. Only pop fires: count-1.
- Latency:
  - An entry pushed at edge N is visible on pop_* during the cycle after edge N (one-cycle latency, no combinational push-to-pop path).
  - Outputs are driven combinationally from the head storage entry and count only.
- push_ready_o depends only on count, never on pop_ready_i. When full, a push is refused even if a pop occurs in the same cycle. Fetch must hold push_* stable until accepted.
- pop_valid_o & !pop_ready_i: the head holds, and pop_pc_o/pop_instr_o are stable.
- Flush:
  - flush_i high at an edge sets count=0 and rd_ptr=wr_ptr=0.
  - Flush has priority: a push or pop in the same cycle is discarded, and no state from it remains.
  - In the cycle after a flush, pop_valid_o=0 and pop_instr_o=NOP_INSTR.
- Edge cases:
  - pop_ready_i while empty has no effect; count never underflows.
  - push_valid_i while full has no effect; count never exceeds DEPTH.
  - Pointer wrap from DEPTH-1 to 0 is silent and does not disturb ordering.
- Ordering is strict FIFO; PC and instruction of an entry always stay paired.

Test Plan:
- Reset then idle: rst_i low for 2 cycles, then high. Required: pop_valid_o=0, pop_instr_o=32'h00000013, pop_pc_o=0, count_o=0, push_ready_o=1.
- Single push/pop:
  - Push pc=0x0000_0004, instr=0x00A00093 with pop_ready_i=0.
  - Next cycle: pop_valid_o=1, pop_pc_o=0x4, pop_instr_o=0x00A00093, count_o=1.
  - Raise pop_ready_i for 1 cycle: count_o=0 and the NOP returns.
- Fill and back-pressure:
  - Push pc 0x0, 0x4, 0x8 on consecutive cycles with pop_ready_i=0.
  - Required: after 2 pushes push_ready_o=0 and count_o=2; the 0x8 push is not accepted.
  - Then pop: order is 0x0, then 0x4, then 0x8 (accepted once space frees).
- Simultaneous push/pop at count=1: push 0xC while popping 0x8. Required: count_o stays 1, and the next head is pc=0xC.
- Flush priority:
  - With count_o=2, assert flush_i together with a push of pc=0x20 and pop_ready_i=1.
  - Required next cycle: count_o=0, pop_valid_o=0.
  - A subsequent push of pc=0x40 appears as head with count_o=1.
- Async reset mid-stream: with count_o=2, drop rst_i between clock edges. Required: count_o=0, pop_valid_o=0, push_ready_o=1 immediately, before the next edge.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue
// -----------
// Instruction buffer between fetch and decode. It holds {pc, instruction}
// pairs pushed by fetch and presents the oldest one to decode through a
// valid/ready handshake. When the buffer is empty, decode sees pc=0 and a
// canonical NOP, so the immediate generator and control decode get benign
// input. A flush discards every entry, including wrong-path fetches.
//
// Parameters:
//   DEPTH     number of entries (power of two, >= 2)
//   PTR_W     log2(DEPTH)
//   NOP_INSTR instruction presented while empty (addi x0,x0,0)
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active low
//   flush_i       drop all entries at the next edge (has priority)
//   push_valid_i  fetch offers {push_pc_i, push_instr_i}
//   push_ready_o  queue not full (depends on count only)
//   push_pc_i     PC of the offered instruction
//   push_instr_i  offered instruction word
//   pop_valid_o   head entry valid (queue not empty)
//   pop_ready_i   decode consumes the head
//   pop_pc_o      head PC, 0 when empty
//   pop_instr_o   head instruction, NOP_INSTR when empty
//   count_o       number of valid entries, 0..DEPTH

module if_id_queue #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned PTR_W     = 1,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [31:0]      push_pc_i,
  input  logic [31:0]      push_instr_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [31:0]      pop_pc_o,
  output logic [31:0]      pop_instr_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             full;
  logic             empty;
  logic             push_fire;
  logic             pop_fire;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);

  // Acceptance is decided from count alone: a pop in the same cycle does
  // not open a slot for a push while full.
  assign push_fire = push_valid_i & ~full;
  assign pop_fire  = pop_ready_i & ~empty;

  // Pointers and occupancy. Flush outranks any push/pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by count only.
  // Writes are suppressed on flush so a flushed push leaves no trace.
  always_ff @(posedge clk_i) begin
    if (push_fire && !flush_i) begin
      pc_mem[wr_ptr]    <= push_pc_i;
      instr_mem[wr_ptr] <= push_instr_i;
    end
  end

  // Outputs come from registered state only: no push-to-pop bypass.
  always_comb begin
    push_ready_o = ~full;
    pop_valid_o  = ~empty;
    count_o      = count;
    if (empty) begin
      pop_pc_o    = '0;
      pop_instr_o = NOP_INSTR;
    end else begin
      pop_pc_o    = pc_mem[rd_ptr];
      pop_instr_o = instr_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue. A queue of expected {pc, instr}
// pairs is filled as pushes are accepted and drained as pops are taken;
// each test task compares DUT outputs against it inline.

module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PTR_W = 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk;
  logic             rst_i;
  logic             flush_i;
  logic             push_valid_i;
  logic             push_ready_o;
  logic [31:0]      push_pc_i;
  logic [31:0]      push_instr_i;
  logic             pop_valid_o;
  logic             pop_ready_i;
  logic [31:0]      pop_pc_o;
  logic [31:0]      pop_instr_o;
  logic [PTR_W:0]   count_o;

  logic [63:0]      sb[$];
  int               tests;
  int               fails;

  if_id_queue #(
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .push_ready_o (push_ready_o),
    .push_pc_i    (push_pc_i),
    .push_instr_i (push_instr_i),
    .pop_valid_o  (pop_valid_o),
    .pop_ready_i  (pop_ready_i),
    .pop_pc_o     (pop_pc_o),
    .pop_instr_o  (pop_instr_o),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, let the edge happen, and update the
  // expected-contents queue from the bench's own view of acceptance.
  task automatic tick(input logic fl, input logic pv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic pr);
    logic pfire;
    logic popf;
    flush_i      = fl;
    push_valid_i = pv;
    push_pc_i    = pc;
    push_instr_i = ins;
    pop_ready_i  = pr;
    pfire = pv && (sb.size() < DEPTH);
    popf  = pr && (sb.size() > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (popf) void'(sb.pop_front());
      if (pfire) sb.push_back({pc, ins});
    end
    flush_i      = 1'b0;
    push_valid_i = 1'b0;
    pop_ready_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    flush_i = 1'b0; push_valid_i = 1'b0; pop_ready_i = 1'b0;
    push_pc_i = '0; push_instr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    sb.delete();
    @(negedge clk);
    tests++; if (pop_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", pop_valid_o); end
    tests++; if (pop_instr_o !== NOP) begin fails++; $display("FAIL reset_instr: got %h want %h", pop_instr_o, NOP); end
    tests++; if (pop_pc_o !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", pop_pc_o); end
    tests++; if (count_o !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count_o); end
    tests++; if (push_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", push_ready_o); end
  endtask

  task automatic test_single_push_pop();
    tick(1'b0, 1'b1, 32'h0000_0004, 32'h00A0_0093, 1'b0);
    tests++; if (pop_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", pop_valid_o); end
    tests++; if (pop_pc_o !== sb[0][63:32]) begin fails++; $display("FAIL single_pc: got %h want %h", pop_pc_o, sb[0][63:32]); end
    tests++; if (pop_instr_o !== 32'h00A0_0093) begin fails++; $display("FAIL single_instr: got %h want 00a00093", pop_instr_o); end
    tests++; if (count_o !== 2'd1) begin fails++; $display("FAIL single_count: got %0d want 1", count_o); end
    tick(1'b0, 1'b0, '0, '0, 1'b1);
    tests++; if (count_o !== 2'd0) begin fails++; $display("FAIL single_drain_count: got %0d want 0", count_o); end
    tests++; if (pop_instr_o !== NOP) begin fails++; $display("FAIL single_nop: got %h want %h", pop_instr_o, NOP); end
  endtask

  task automatic test_fill_backpressure();
    tick(1'b0, 1'b1, 32'h0, 32'h1111_0013, 1'b0);
    tick(1'b0, 1'b1, 32'h4, 32'h2222_0013, 1'b0);
    tests++; if (push_ready_o !== 1'b0) begin fails++; $display("FAIL fill_ready: got %b want 0", push_ready_o); end
    tests++; if (count_o !== 2'd2) begin fails++; $display("FAIL fill_count: got %0d want 2", count_o); end
    tick(1'b0, 1'b1, 32'h8, 32'h3333_0013, 1'b0);
    tests++; if (count_o !== 2'd2) begin fails++; $display("FAIL full_refuse_count: got %0d want 2", count_o); end
    tests++; if (pop_pc_o !== 32'h0) begin fails++; $display("FAIL full_head: got %h want 0", pop_pc_o); end
    // Pop while full with 0x8 still offered: the push must still be refused.
    tests++; if (pop_pc_o !== sb[0][63:32]) begin fails++; $display("FAIL order0_pc: got %h want %h", pop_pc_o, sb[0][63:32]); end
    tick(1'b0, 1'b1, 32'h8, 32'h3333_0013, 1'b1);
    tests++; if (count_o !== 2'd1) begin fails++; $display("FAIL full_pop_count: got %0d want 1", count_o); end
    tests++; if (pop_pc_o !== 32'h4) begin fails++; $display("FAIL order1_pc: got %h want 4", pop_pc_o); end
    tests++; if (pop_instr_o !== 32'h2222_0013) begin fails++; $display("FAIL order1_instr: got %h want 22220013", pop_instr_o); end
    tick(1'b0, 1'b1, 32'h8, 32'h3333_0013, 1'b1);
    tests++; if (pop_pc_o !== 32'h8) begin fails++; $display("FAIL order2_pc: got %h want 8", pop_pc_o); end
    tests++; if (count_o !== 2'd1) begin fails++; $display("FAIL order2_count: got %0d want 1", count_o); end
  endtask

  task automatic test_simultaneous();
    tick(1'b0, 1'b1, 32'hC, 32'h4444_0013, 1'b1);
    tests++; if (count_o !== 2'd1) begin fails++; $display("FAIL simul_count: got %0d want 1", count_o); end
    tests++; if (pop_pc_o !== 32'hC) begin fails++; $display("FAIL simul_head_pc: got %h want c", pop_pc_o); end
    tests++; if (pop_instr_o !== 32'h4444_0013) begin fails++; $display("FAIL simul_head_instr: got %h want 44440013", pop_instr_o); end
    tick(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_flush();
    tick(1'b0, 1'b1, 32'h10, 32'h5555_0013, 1'b0);
    tick(1'b0, 1'b1, 32'h14, 32'h6666_0013, 1'b0);
    tests++; if (count_o !== 2'd2) begin fails++; $display("FAIL flush_pre_count: got %0d want 2", count_o); end
    tick(1'b1, 1'b1, 32'h20, 32'h7777_0013, 1'b1);
    tests++; if (count_o !== 2'd0) begin fails++; $display("FAIL flush_count: got %0d want 0", count_o); end
    tests++; if (pop_valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", pop_valid_o); end
    tests++; if (pop_instr_o !== NOP) begin fails++; $display("FAIL flush_nop: got %h want %h", pop_instr_o, NOP); end
    tick(1'b0, 1'b1, 32'h40, 32'h8888_0013, 1'b0);
    tests++; if (pop_pc_o !== 32'h40) begin fails++; $display("FAIL flush_next_pc: got %h want 40", pop_pc_o); end
    tests++; if (pop_instr_o !== 32'h8888_0013) begin fails++; $display("FAIL flush_next_instr: got %h want 88880013", pop_instr_o); end
    tests++; if (count_o !== 2'd1) begin fails++; $display("FAIL flush_next_count: got %0d want 1", count_o); end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1, 32'h44, 32'h9999_0013, 1'b0);
    tests++; if (count_o !== 2'd2) begin fails++; $display("FAIL areset_pre_count: got %0d want 2", count_o); end
    #2;
    rst_i = 1'b0;
    #1;
    // Still well before the next rising edge.
    tests++; if (count_o !== 2'd0) begin fails++; $display("FAIL areset_count: got %0d want 0", count_o); end
    tests++; if (pop_valid_o !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b want 0", pop_valid_o); end
    tests++; if (push_ready_o !== 1'b1) begin fails++; $display("FAIL areset_ready: got %b want 1", push_ready_o); end
    tests++; if (pop_instr_o !== NOP) begin fails++; $display("FAIL areset_nop: got %h want %h", pop_instr_o, NOP); end
    sb.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
  endtask

  // Random traffic with occasional flushes; fetch holds its offer until
  // the bench sees it accepted, and every taken pop is checked in order.
  task automatic test_back_to_back();
    logic [31:0] pc;
    logic        pv;
    logic        pr;
    logic        fl;
    logic        accepted;
    pc = 32'h1000;
    for (int unsigned i = 0; i < 400; i++) begin
      pv = ($urandom_range(0, 3) != 0);
      pr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 31) == 0);
      #1;
      if (pop_valid_o !== (sb.size() > 0)) begin
        tests++; fails++;
        $display("FAIL b2b_valid: got %b want %b", pop_valid_o, sb.size() > 0);
      end
      if (pr && sb.size() > 0) begin
        tests++;
        if ({pop_pc_o, pop_instr_o} !== sb[0]) begin
          fails++;
          $display("FAIL b2b_pop: got %h/%h want %h/%h", pop_pc_o, pop_instr_o, sb[0][63:32], sb[0][31:0]);
        end
      end
      accepted = pv && !fl && (sb.size() < DEPTH);
      tick(fl, pv, pc, pc ^ 32'hA5A5_0013, pr);
      tests++;
      if (count_o !== (PTR_W + 1)'(sb.size())) begin
        fails++;
        $display("FAIL b2b_count: got %0d want %0d", count_o, sb.size());
      end
      if (accepted || fl) pc = pc + 32'h4;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_push_pop();
    test_fill_backpressure();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
